// File: rtl/latch_write_seq.sv
// latch_write_seq: sequences writes into a bank of transparent data latches.
// Each accepted write drives the shared data bus, waits SETUP cycles, pulses
// the addressed gate for PULSE cycles, then holds the data for HOLD cycles.
// Optional feature (macro LATCH_WRITE_SEQ_CLEAR_EN): a clr_req in IDLE runs a
// CLEAR phase that drives clr_n_out low for PULSE cycles.
//
// Handshake: a write is accepted on a rising edge where in_valid && in_ready.
// in_ready is high only in IDLE (and, with the clear feature, only when no
// clear is requested); in_addr/in_data are sampled only on that edge and are
// ignored at all other times, so a held in_valid simply waits for IDLE.
module latch_write_seq #(
  parameter int WIDTH   = 8,
  parameter int N_LATCH = 3,
  parameter int SETUP   = 1,
  parameter int PULSE   = 2,
  parameter int HOLD    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_addr,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               clr_req,
  output logic [WIDTH-1:0]   d_out,
  output logic [N_LATCH-1:0] g_out,
  output logic               clr_n_out,
  output logic               busy,
  output logic               addr_err,
  output logic [2:0]         dbg_state
);

`ifdef LATCH_WRITE_SEQ_CLEAR_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_GATE  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_CLEAR = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_GATE  = 3'd2,
    ST_HOLD  = 3'd3
  } state_t;
`endif

  // Phase counters load "length - 1" so that a phase of n cycles ends at zero.
  localparam logic [3:0] SETUP_LD = 4'(SETUP - 1);
  localparam logic [3:0] PULSE_LD = 4'(PULSE - 1);
  localparam logic [3:0] HOLD_LD  = 4'(HOLD - 1);

  state_t               state_q;
  logic [3:0]           cnt_q;
  logic [WIDTH-1:0]     data_q;
  logic [1:0]           addr_q;
  logic                 bad_q;
  logic [N_LATCH-1:0]   gate_q;
  logic                 clr_n_q;
  logic                 addr_err_q;
  logic                 accept;
  logic                 addr_bad;

  // One-hot gate vector for a latch index; out-of-range indices give all zero.
  function automatic logic [N_LATCH-1:0] gate_for(input logic [1:0] a);
    logic [N_LATCH-1:0] g;
    g = '0;
    for (int i = 0; i < N_LATCH; i++) begin
      if (a == 2'(i)) g[i] = 1'b1;
    end
    return g;
  endfunction

  // Ready only in IDLE outside reset; a pending clear takes priority when enabled.
  always_comb begin
`ifdef LATCH_WRITE_SEQ_CLEAR_EN
    in_ready = (state_q == ST_IDLE) && !rst && !clr_req;
`else
    in_ready = (state_q == ST_IDLE) && !rst;
`endif
  end

  assign accept   = in_valid && in_ready;
  assign addr_bad = ({1'b0, in_addr} >= 3'(N_LATCH));

  // Sequencer: state, phase counter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      data_q     <= '0;
      addr_q     <= 2'd0;
      bad_q      <= 1'b0;
      gate_q     <= '0;
      clr_n_q    <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      // Clear is released on the first edge out of reset and whenever not clearing.
      clr_n_q    <= 1'b1;
      addr_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
`ifdef LATCH_WRITE_SEQ_CLEAR_EN
          if (clr_req) begin
            state_q <= ST_CLEAR;
            cnt_q   <= PULSE_LD;
            clr_n_q <= 1'b0;
          end else
`endif
          if (accept) begin
            state_q    <= ST_SETUP;
            cnt_q      <= SETUP_LD;
            data_q     <= in_data;
            addr_q     <= in_addr;
            bad_q      <= addr_bad;
            addr_err_q <= addr_bad;
          end
        end
        ST_SETUP: begin
          if (cnt_q == 4'd0) begin
            state_q <= ST_GATE;
            cnt_q   <= PULSE_LD;
            gate_q  <= bad_q ? '0 : gate_for(addr_q);
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_GATE: begin
          if (cnt_q == 4'd0) begin
            state_q <= ST_HOLD;
            cnt_q   <= HOLD_LD;
            gate_q  <= '0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_HOLD: begin
          if (cnt_q == 4'd0) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
`ifdef LATCH_WRITE_SEQ_CLEAR_EN
        ST_CLEAR: begin
          if (cnt_q == 4'd0) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q   <= cnt_q - 4'd1;
            clr_n_q <= 1'b0;
          end
        end
`endif
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= 4'd0;
          gate_q  <= '0;
        end
      endcase
    end
  end

  assign d_out     = data_q;
  assign g_out     = gate_q;
  assign clr_n_out = clr_n_q;
  assign busy      = (state_q != ST_IDLE);
  assign addr_err  = addr_err_q;
  assign dbg_state = state_q;

endmodule

// File: doc/latch_write_seq.md
LATCH_WRITE_SEQ -- requirements
Module: latch_write_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data width of d_out and in_data.
REQ-002 The block SHALL have parameter N_LATCH, default 3, meaning number of downstream data latches (one gate each, N_LATCH <= 4).
REQ-003 The block SHALL have parameters SETUP, PULSE and HOLD, defaults 1, 2 and 1, meaning the cycle counts for each phase (each >= 1, each <= 15).
REQ-004 The block SHALL have port clk, input, 1, system clock, rising-edge active.
REQ-005 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1, write request valid.
REQ-007 The block SHALL have port in_ready, output, 1, write request accepted this cycle when high with in_valid.
REQ-008 The block SHALL have port in_addr, input, 2, target latch index.
REQ-009 The block SHALL have port in_data, input, WIDTH, data to be latched.
REQ-010 The block SHALL have port clr_req, input, 1, request to clear all latches.
REQ-011 The block SHALL have port d_out, output, WIDTH, shared data bus to the latch d inputs.
REQ-012 The block SHALL have port g_out, output, N_LATCH, one-hot gate enables to the latch g inputs.
REQ-013 The block SHALL have port clr_n_out, output, 1, active-low clear to all latches.
REQ-014 The block SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.
REQ-015 The block SHALL have port addr_err, output, 1, one-cycle pulse on acceptance of an out-of-range address.

Function
REQ-016 The FSM SHALL have exactly five states: IDLE, SETUP, GATE, HOLD and CLEAR.
REQ-017 in_ready SHALL equal 1 only in IDLE with rst low and clr_req low; it SHALL be combinational from state and clr_req.
REQ-018 On a rising edge in IDLE with in_valid=1 and in_ready=1, the block SHALL register in_data into d_out and in_addr internally, then enter SETUP.
REQ-019 SETUP SHALL last SETUP cycles with g_out=0 and d_out stable, then go to GATE.
REQ-020 GATE SHALL last PULSE cycles with g_out[addr]=1 and all other bits 0, then go to HOLD.
REQ-021 HOLD SHALL last HOLD cycles with g_out=0 and d_out unchanged, then return to IDLE.
REQ-022 Each accepted write SHALL keep busy high for exactly SETUP+PULSE+HOLD cycles; the next acceptance is possible on the first IDLE cycle.
REQ-023 If in_addr >= N_LATCH, the block SHALL pulse addr_err for one cycle on acceptance, keep g_out=0 throughout, and still run the full SETUP/GATE/HOLD timing.
REQ-024 d_out SHALL change only on acceptance and SHALL hold its value in IDLE and CLEAR.
REQ-025 g_out SHALL be driven from registers and SHALL never have more than one bit set.
REQ-026 In clr_n_out active cycles, g_out SHALL be 0.
REQ-027 Requests arriving while busy SHALL be ignored; in_ready=0 enforces back-pressure, and in_valid/in_data SHALL be sampled only on acceptance.
REQ-028 The phase counter SHALL be 4 bits wide, load phase-1 on entry, and move to the next state at zero, with no wrap.

Reset
REQ-029 While rst=1, asynchronously: state=IDLE, d_out=0, g_out=0, clr_n_out=0, busy=0, addr_err=0, in_ready=0, counter=0.
REQ-030 clr_n_out SHALL return to 1 on the first rising clk after rst deasserts, so the latches are cleared throughout reset.
REQ-031 Reset asserted mid-sequence SHALL abort immediately and drop any gate pulse in progress without completing it.

Configuration
REQ-032 With macro LATCH_WRITE_SEQ_CLEAR_EN defined: clr_req in IDLE enters CLEAR, which drives clr_n_out=0 for PULSE cycles and then returns to IDLE.
REQ-033 With LATCH_WRITE_SEQ_CLEAR_EN defined: clr_req wins over in_valid in the same IDLE cycle, and clr_req while busy is ignored rather than queued.
REQ-034 Without LATCH_WRITE_SEQ_CLEAR_EN: the CLEAR state is absent, clr_req is ignored, in_ready does not depend on clr_req, and clr_n_out is 1 except during reset per REQ-029/030.

Verification
REQ-035 Reset with defaults: rst=1 -> g_out=0, d_out=0, clr_n_out=0; release rst -> clr_n_out=1 after 1 clk, and in_ready=1.
REQ-036 Single write with addr=1, data=8'hA5 -> d_out=A5 from the next cycle; g_out=3'b010 exactly in cycles 2-3 after acceptance; busy high for 4 cycles.
REQ-037 Back-to-back writes (0,8'h11) then (2,8'h22) with in_valid held -> second acceptance on the first IDLE cycle; g_out=001 then 100, never overlapping.
REQ-038 Write with addr=3 -> addr_err=1 for one cycle, g_out remains 0, and busy lasts 4 cycles.
REQ-039 rst pulsed during GATE of a write to addr=0 -> g_out drops to 0 immediately, and the FSM is in IDLE after release.
REQ-040 With CLEAR_EN, clr_req and in_valid together in IDLE -> clr_n_out=0 for 2 cycles, the write is not accepted, and it is accepted after CLEAR ends; without CLEAR_EN, clr_req has no effect.
